// File: rtl/hbus_arb.sv
// Round-robin arbiter between per-hart line ports and one system memory port.
// Serialises one line transaction at a time, broadcasts write invalidations and owns the AMO lock.
`ifndef HMEM_LINE
`define HMEM_LINE 512
`endif

module hbus_arb #(
    parameter int N_HARTS = 2,
    parameter int LINE_W  = `HMEM_LINE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_HARTS*64-1:0]       h_addr,
    input  logic [N_HARTS-1:0]          h_rd,
    input  logic [N_HARTS-1:0]          h_wr,
    input  logic [N_HARTS*LINE_W-1:0]   h_data_out,
    output logic [LINE_W-1:0]           h_data_in,
    output logic [N_HARTS-1:0]          h_dv,
    output logic [63:0]                 h_inv_addr,
    output logic [N_HARTS-1:0]          h_inv,
    input  logic [N_HARTS-1:0]          h_amo_req,
    output logic [N_HARTS-1:0]          h_amo_ack,
    output logic [63:0]                 m_addr,
    output logic                        m_rd,
    output logic                        m_wr,
    output logic [LINE_W-1:0]           m_data_out,
    input  logic [LINE_W-1:0]           m_data_in,
    input  logic                        m_dv
);
    localparam int IW = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          g_q, g_d, rr_q, rr_d, own_q, own_d;
    logic                   wr_q, wr_d, mask_q, mask_d, lock_q, lock_d;
    logic                   m_rd_q, m_rd_d, m_wr_q, m_wr_d;
    logic [63:0]            addr_q, addr_d, inv_addr_q, inv_addr_d;
    logic [LINE_W-1:0]      rdata_q, rdata_d;
    logic [N_HARTS-1:0]     dv_q, dv_d, inv_q, inv_d, ack_q, ack_d;

    logic [63:0]            addr_arr [N_HARTS];
    logic [LINE_W-1:0]      line_arr [N_HARTS];

    for (genvar gi = 0; gi < N_HARTS; gi++) begin : g_slice
        assign addr_arr[gi] = h_addr[64*gi +: 64];
        assign line_arr[gi] = h_data_out[LINE_W*gi +: LINE_W];
    end

    // Eligibility: lock owner only while locked; the just-served hart sits out one IDLE cycle.
    logic [N_HARTS-1:0]     elig;
    logic                   found;
    logic [IW-1:0]          pick;

    always_comb begin : p_pick
        int idx;
        idx   = 0;
        elig  = h_rd | h_wr;
        if (lock_q) elig &= (N_HARTS'(1) << own_q);
        if (mask_q) elig &= ~(N_HARTS'(1) << g_q);
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < N_HARTS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= N_HARTS) idx -= N_HARTS;
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_comb begin : p_lock
        lock_d = lock_q;
        own_d  = own_q;
        ack_d  = ack_q;
        if (lock_q) begin
            if (!h_amo_req[own_q]) begin
                lock_d = 1'b0;
                ack_d  = '0;
            end
        end else if (|h_amo_req) begin
            lock_d = 1'b1;
            for (int i = N_HARTS - 1; i >= 0; i--) begin
                if (h_amo_req[i]) own_d = IW'(i);
            end
            ack_d = N_HARTS'(1) << own_d;
        end
    end

    always_comb begin : p_fsm
        state_d    = state_q;
        g_d        = g_q;
        rr_d       = rr_q;
        wr_d       = wr_q;
        mask_d     = mask_q;
        addr_d     = addr_q;
        inv_addr_d = inv_addr_q;
        rdata_d    = rdata_q;
        m_rd_d     = m_rd_q;
        m_wr_d     = m_wr_q;
        dv_d       = '0;
        inv_d      = '0;
        case (state_q)
            IDLE: begin
                mask_d = 1'b0;
                if (found) begin
                    g_d    = pick;
                    addr_d = addr_arr[pick];
                    wr_d   = h_wr[pick];
                    rr_d   = (pick == IW'(N_HARTS - 1)) ? '0 : pick + 1'b1;
                    if (h_wr[pick]) begin
                        m_wr_d  = 1'b1;
                        state_d = WR;
                    end else begin
                        m_rd_d  = 1'b1;
                        state_d = RD;
                    end
                end
            end
            RD, WR: begin
                if (m_dv) begin
                    m_rd_d  = 1'b0;
                    m_wr_d  = 1'b0;
                    dv_d    = N_HARTS'(1) << g_q;
                    state_d = DONE;
                    if (wr_q) begin
                        inv_d      = ~(N_HARTS'(1) << g_q);
                        inv_addr_d = addr_q;
                    end else begin
                        rdata_d = m_data_in;
                    end
                end
            end
            default: begin
                mask_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            g_q        <= '0;
            rr_q       <= '0;
            own_q      <= '0;
            wr_q       <= 1'b0;
            mask_q     <= 1'b0;
            lock_q     <= 1'b0;
            m_rd_q     <= 1'b0;
            m_wr_q     <= 1'b0;
            addr_q     <= '0;
            inv_addr_q <= '0;
            rdata_q    <= '0;
            dv_q       <= '0;
            inv_q      <= '0;
            ack_q      <= '0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            rr_q       <= rr_d;
            own_q      <= own_d;
            wr_q       <= wr_d;
            mask_q     <= mask_d;
            lock_q     <= lock_d;
            m_rd_q     <= m_rd_d;
            m_wr_q     <= m_wr_d;
            addr_q     <= addr_d;
            inv_addr_q <= inv_addr_d;
            rdata_q    <= rdata_d;
            dv_q       <= dv_d;
            inv_q      <= inv_d;
            ack_q      <= ack_d;
        end
    end

    assign m_rd       = m_rd_q;
    assign m_wr       = m_wr_q;
    assign m_addr     = addr_q;
    // The writing hart holds its line stable, so it is forwarded live while the write is open.
    assign m_data_out = m_wr_q ? line_arr[g_q] : '0;
    assign h_data_in  = rdata_q;
    assign h_dv       = dv_q;
    assign h_inv      = inv_q;
    assign h_inv_addr = inv_addr_q;
    assign h_amo_ack  = ack_q;

endmodule

// File: tb/tb_hbus_arb.sv
// Directed bench for hbus_arb (2 harts, 64-bit lines): read, write/invalidate, fairness, AMO lock, reset.
module tb_hbus_arb;
    localparam int N  = 2;
    localparam int LW = 64;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N*64-1:0]    h_addr;
    logic [N-1:0]       h_rd, h_wr;
    logic [N*LW-1:0]    h_data_out;
    logic [LW-1:0]      h_data_in;
    logic [N-1:0]       h_dv;
    logic [63:0]        h_inv_addr;
    logic [N-1:0]       h_inv;
    logic [N-1:0]       h_amo_req, h_amo_ack;
    logic [63:0]        m_addr;
    logic               m_rd, m_wr;
    logic [LW-1:0]      m_data_out, m_data_in;
    logic               m_dv;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hbus_arb #(.N_HARTS(N), .LINE_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .h_addr(h_addr), .h_rd(h_rd), .h_wr(h_wr), .h_data_out(h_data_out),
        .h_data_in(h_data_in), .h_dv(h_dv), .h_inv_addr(h_inv_addr), .h_inv(h_inv),
        .h_amo_req(h_amo_req), .h_amo_ack(h_amo_ack),
        .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_data_out(m_data_out),
        .m_data_in(m_data_in), .m_dv(m_dv)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bounded wait (at negedges) for the arbiter to open a memory access.
    task automatic wait_mem(input string tag);
        int cnt = 0;
        while (!(m_rd || m_wr) && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, " mem req"}, 64'(m_rd | m_wr), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; h_addr = '0; h_rd = '0; h_wr = '0; h_data_out = '0;
        h_amo_req = '0; m_data_in = '0; m_dv = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst m_rd", 64'(m_rd), 64'd0);
        chk("rst m_wr", 64'(m_wr), 64'd0);
        chk("rst h_dv", 64'(h_dv), 64'd0);
        chk("rst h_inv", 64'(h_inv), 64'd0);
        chk("rst ack", 64'(h_amo_ack), 64'd0);
        chk("rst m_addr", m_addr, 64'd0);
        chk("rst h_data_in", 64'(h_data_in), 64'd0);
        chk("rst m_data_out", 64'(m_data_out), 64'd0);
        rst_n = 1'b1;

        // write + invalidate, hart 0, one-cycle memory latency
        h_addr[63:0] = 64'h1000;
        h_data_out[63:0] = 64'h1111_2222_3333_4444;
        h_data_out[127:64] = 64'hDEAD_BEEF_0000_0001;
        h_wr = 2'b01;
        @(negedge clk);
        chk("wr m_wr", 64'(m_wr), 64'd1);
        chk("wr m_rd", 64'(m_rd), 64'd0);
        chk("wr m_addr", m_addr, 64'h1000);
        chk("wr m_data_out", 64'(m_data_out), 64'h1111_2222_3333_4444);
        m_dv = 1'b1;
        @(negedge clk); m_dv = 1'b0;
        chk("wr h_dv", 64'(h_dv), 64'd1);
        chk("wr h_inv", 64'(h_inv), 64'd2);
        chk("wr h_inv_addr", h_inv_addr, 64'h1000);
        chk("wr m_wr drop", 64'(m_wr), 64'd0);
        h_wr = 2'b00;
        @(negedge clk);
        chk("wr h_dv pulse", 64'(h_dv), 64'd0);
        chk("wr h_inv pulse", 64'(h_inv), 64'd0);

        // single read, hart 1, m_dv in fourth memory cycle
        h_addr[127:64] = 64'h8000_0040;
        h_rd = 2'b10;
        @(negedge clk);
        chk("rd m_rd", 64'(m_rd), 64'd1);
        chk("rd m_addr", m_addr, 64'h8000_0040);
        repeat (3) @(negedge clk);
        chk("rd m_rd held", 64'(m_rd), 64'd1);
        chk("rd no early h_dv", 64'(h_dv), 64'd0);
        m_dv = 1'b1; m_data_in = 64'hA5A5_A5A5_A5A5_A5A5;
        @(negedge clk); m_dv = 1'b0; m_data_in = '0;
        chk("rd h_dv", 64'(h_dv), 64'd2);
        chk("rd h_data_in", 64'(h_data_in), 64'hA5A5_A5A5_A5A5_A5A5);
        chk("rd h_inv", 64'(h_inv), 64'd0);
        @(negedge clk);
        chk("rd h_dv pulse", 64'(h_dv), 64'd0);
        // hart 1 keeps its request through the first IDLE cycle, then drops it
        @(negedge clk); h_rd = 2'b00;
        chk("mask no regrant", 64'(m_rd), 64'd0);
        @(negedge clk);
        chk("mask idle", 64'(m_rd), 64'd0);

        // fairness: both harts read continuously; rr points at hart 0
        h_addr[63:0] = 64'hA0;
        h_addr[127:64] = 64'hB0;
        h_rd = 2'b11;
        for (int t = 0; t < 8; t++) begin
            wait_mem($sformatf("fair%0d", t));
            chk($sformatf("fair%0d addr", t), m_addr, (t % 2 == 1) ? 64'hB0 : 64'hA0);
            m_dv = 1'b1; m_data_in = 64'(t + 16);
            @(negedge clk); m_dv = 1'b0;
            chk($sformatf("fair%0d h_dv", t), 64'(h_dv), (t % 2 == 1) ? 64'd2 : 64'd1);
            chk($sformatf("fair%0d data", t), 64'(h_data_in), 64'(t + 16));
            if (t == 7) h_rd = 2'b00;
        end

        // hart 0 requests read and write together: write goes first
        h_addr[63:0] = 64'h2000;
        h_data_out[63:0] = 64'h5555;
        h_rd = 2'b01; h_wr = 2'b01;
        wait_mem("rw first");
        chk("rw m_wr", 64'(m_wr), 64'd1);
        chk("rw m_rd", 64'(m_rd), 64'd0);
        chk("rw m_data_out", 64'(m_data_out), 64'h5555);
        m_dv = 1'b1;
        @(negedge clk); m_dv = 1'b0;
        chk("rw h_dv", 64'(h_dv), 64'd1);
        chk("rw h_inv", 64'(h_inv), 64'd2);
        chk("rw h_inv_addr", h_inv_addr, 64'h2000);
        h_wr = 2'b00;
        wait_mem("rw second");
        chk("rw2 m_rd", 64'(m_rd), 64'd1);
        chk("rw2 m_wr", 64'(m_wr), 64'd0);
        chk("rw2 m_data_out", 64'(m_data_out), 64'd0);
        m_dv = 1'b1; m_data_in = 64'h77;
        @(negedge clk); m_dv = 1'b0;
        chk("rw2 h_dv", 64'(h_dv), 64'd1);
        chk("rw2 h_data_in", 64'(h_data_in), 64'h77);
        h_rd = 2'b00;
        @(negedge clk);

        // AMO lock taken by hart 1 while hart 0 read is in flight
        h_addr[63:0] = 64'h3000;
        h_rd = 2'b01;
        wait_mem("amo rd");
        h_amo_req = 2'b10;
        @(negedge clk);
        chk("amo ack", 64'(h_amo_ack), 64'd2);
        chk("amo no abort", 64'(m_rd), 64'd1);
        m_dv = 1'b1; m_data_in = 64'h99;
        @(negedge clk); m_dv = 1'b0;
        chk("amo rd h_dv", 64'(h_dv), 64'd1);
        chk("amo rd data", 64'(h_data_in), 64'h99);
        h_rd = 2'b00;
        @(negedge clk);
        h_addr[63:0] = 64'h3040;
        h_rd = 2'b01;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk($sformatf("amo stall%0d", s), 64'(m_rd), 64'd0);
        end
        h_amo_req = 2'b01;
        @(negedge clk);
        chk("amo release ack", 64'(h_amo_ack), 64'd0);
        chk("amo release m_rd", 64'(m_rd), 64'd0);
        @(negedge clk);
        chk("amo regrant ack", 64'(h_amo_ack), 64'd1);
        chk("amo unstall m_rd", 64'(m_rd), 64'd1);
        chk("amo unstall addr", m_addr, 64'h3040);
        m_dv = 1'b1; m_data_in = 64'hCC;
        @(negedge clk); m_dv = 1'b0;
        chk("amo rd2 h_dv", 64'(h_dv), 64'd1);
        h_rd = 2'b00; h_amo_req = 2'b00;
        @(negedge clk);
        chk("amo drop ack", 64'(h_amo_ack), 64'd0);

        // reset during a read with memory response still pending
        h_addr[127:64] = 64'h4000;
        h_rd = 2'b10;
        h_amo_req = 2'b01;
        wait_mem("rst rd");
        chk("rst rd lock", 64'(h_amo_ack), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst m_rd", 64'(m_rd), 64'd0);
        chk("arst ack", 64'(h_amo_ack), 64'd0);
        chk("arst m_addr", m_addr, 64'd0);
        chk("arst h_data_in", 64'(h_data_in), 64'd0);
        chk("arst h_inv_addr", h_inv_addr, 64'd0);
        h_amo_req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("arst h_dv", 64'(h_dv), 64'd0);
        chk("arst m_rd held", 64'(m_rd), 64'd0);
        rst_n = 1'b1;
        wait_mem("post rst");
        chk("post rst addr", m_addr, 64'h4000);
        chk("post rst m_rd", 64'(m_rd), 64'd1);
        m_dv = 1'b1; m_data_in = 64'hEE;
        @(negedge clk); m_dv = 1'b0;
        chk("post rst h_dv", 64'(h_dv), 64'd2);
        chk("post rst data", 64'(h_data_in), 64'hEE);
        h_rd = 2'b00;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hbus_arb.md
# hbus_arb

Shared-memory arbiter that sits between N harts' line-level memory ports (after each hart's L2) and the single system memory port. Serializes line reads/writes with round-robin fairness, returns read data, broadcasts write invalidations to the non-writing harts, and owns the global AMO lock (req/ack). One transaction is outstanding at a time.

## Interface
- N_HARTS, 2, number of hart ports (2..8)
- LINE_W, `hmem_line, line width in bits
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- h_addr  in  N_HARTS*64  per-hart line address, slice i = [64*i+:64]
- h_rd  in  N_HARTS  per-hart read request, level, held until h_dv
- h_wr  in  N_HARTS  per-hart write request, level, held until h_dv
- h_data_out  in  N_HARTS*LINE_W  per-hart write line
- h_data_in  out  LINE_W  read line, shared by all harts, valid with h_dv
- h_dv  out  N_HARTS  one-cycle completion pulse to grantee
- h_inv_addr  out  64  invalidation address, shared
- h_inv  out  N_HARTS  one-cycle invalidate pulse
- h_amo_req  in  N_HARTS  AMO lock request, level
- h_amo_ack  out  N_HARTS  AMO lock grant, one-hot or zero
- m_addr  out  64  memory line address
- m_rd  out  1  memory read, level, held until m_dv
- m_wr  out  1  memory write, level, held until m_dv
- m_data_out  out  LINE_W  memory write line
- m_data_in  in  LINE_W  memory read line, valid with m_dv
- m_dv  in  1  memory completion, one cycle

## Operation
- FSM: IDLE, RD, WR, DONE. Registers: state, grant index g, rr pointer, write flag, mask bit, lock owner + lock valid.
- IDLE: eligible = (h_rd|h_wr) of all harts; if lock valid, eligible = owner only; if mask set, previous g excluded. Pick first eligible at or after rr pointer (wrap-around modulo N_HARTS). Register g, address, write flag; go WR if h_wr[g] else RD (h_wr wins when both set). rr pointer <= g+1 mod N_HARTS. Mask cleared every IDLE cycle.
- RD/WR: m_addr = latched addr; m_rd or m_wr = 1; m_data_out = h_data_out slice g (live, hart holds it). On m_dv: capture m_data_in into h_data_in (RD), go DONE.
- DONE: h_dv[g]=1; if write, h_inv[i]=1 for every i != g, h_inv_addr = written address. Set mask, go IDLE.
- AMO lock: when lock free, lowest-index hart with h_amo_req becomes owner; h_amo_ack[owner]=1 from next cycle. Owner drops h_amo_req -> lock cleared next edge, ack drops; new grant no earlier than the following edge (lock free at least one cycle). Lock grant never aborts an in-flight transaction of another hart.
- m_dv outside RD/WR is ignored. Requests deasserted while granted are ignored; transaction still completes.

## Timing
- Reset values: state IDLE, g 0, rr 0, mask 0, lock free; all outputs 0 (h_data_in, h_inv_addr, m_addr, m_data_out 0).
- Reset mid-transaction: immediate return to IDLE, m_rd/m_wr drop asynchronously, no h_dv, lock released.
- Request sampled in IDLE at edge k -> m_rd/m_wr high from cycle k+1.
- m_dv high in cycle j -> h_dv/h_inv high in cycle j+1 only -> IDLE in j+2; earliest next m_rd/m_wr in j+3.
- Minimum round trip with m_dv in first memory cycle: 3 cycles request-to-h_dv.
- Mask guarantees a grantee dropping its request one cycle after h_dv is never regranted spuriously.
- h_amo_req rising at edge k (lock free) -> h_amo_ack high from cycle k+1.
- m_rd, m_wr, h_dv, h_inv, h_amo_ack are register-driven, glitch-free.

## Test plan
- Single read: hart 1 h_rd, addr 0x8000_0040, memory m_dv after 4 cycles with pattern 0xA5.. -> m_addr 0x8000_0040, h_dv=2'b10 for one cycle, h_data_in = pattern, h_inv=0.
- Write + invalidate: hart 0 h_wr addr 0x1000 -> m_wr with hart-0 line, then h_dv=2'b01 and h_inv=2'b10, h_inv_addr 0x1000, same cycle.
- Fairness: both harts hold h_rd continuously, N_HARTS=2 -> grants alternate 0,1,0,1 for 8 transactions; none granted twice consecutively.
- AMO lock: hart 1 asserts h_amo_req while hart 0 read in flight -> hart 0 read completes, h_amo_ack=2'b10 next cycle; further hart 0 requests stalled until hart 1 drops req; ack clears one cycle later.
- Simultaneous h_rd and h_wr on hart 0 -> write performed first (m_wr), read only after re-arbitration.
- Reset asserted during RD with m_dv pending -> m_rd 0 immediately, no h_dv, all outputs 0; after release, new request served normally.
